// File: rtl/branch_target_table.sv
// Small branch target table: each entry holds an absolute target or a PC-relative signed offset.
// After reset or flush the table walks through INIT, writing defaults, before accepting requests.
module branch_target_table #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned TGT_W  = 10,
    parameter int unsigned PC_W   = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              flush,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [PC_W-1:0]   pc_in,
    output logic              rd_valid,
    output logic [PC_W-1:0]   target,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [TGT_W-1:0]  wr_data,
    input  logic              wr_rel,
    output logic              busy
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    if (PC_W < TGT_W) begin : g_param_check
        $error("branch_target_table: PC_W must be >= TGT_W");
    end

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rd_valid_q, rd_valid_d;
    logic [PC_W-1:0]     target_q, target_d;

    // Table storage has no reset; contents become defined only by the INIT walk.
    logic [TGT_W-1:0]    mem_data_q [Depth];
    logic [Depth-1:0]    mem_rel_q;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [TGT_W-1:0]    mem_wdata;
    logic                mem_wrel;

    logic                wr_fire, rd_fire;
    logic [TGT_W-1:0]    rd_data;
    logic                rd_rel;
    logic signed [TGT_W-1:0] rd_sdata;

    assign busy     = (state_q == StInit);
    assign wr_ready = (state_q == StRun) && !flush;
    assign rd_valid = rd_valid_q;
    assign target   = target_q;

    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_en && (state_q == StRun) && !flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wrel  = 1'b0;
        unique case (state_q)
            StInit: begin
                if (flush) begin
                    cnt_d = '0;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q;
                    // Entry 0 defaults to a relative offset of -1.
                    if (cnt_q == '0) begin
                        mem_wdata = '1;
                        mem_wrel  = 1'b1;
                    end
                    if (cnt_q == '1) begin
                        state_d = StRun;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end else if (wr_fire) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr;
                    mem_wdata = wr_data;
                    mem_wrel  = wr_rel;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Write-first: a same-edge write to the read address is forwarded into the read.
    always_comb begin
        rd_data = mem_data_q[rd_addr];
        rd_rel  = mem_rel_q[rd_addr];
        if (wr_fire && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
            rd_rel  = wr_rel;
        end
        rd_sdata   = rd_data;
        rd_valid_d = rd_fire;
        target_d   = target_q;
        if (rd_fire) begin
            if (rd_rel) begin
                target_d = pc_in + PC_W'(rd_sdata);
            end else begin
                target_d = PC_W'(rd_data);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            target_q   <= target_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_data_q[mem_waddr] <= mem_wdata;
            mem_rel_q[mem_waddr]  <= mem_wrel;
        end
    end

endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table: default build plus a wide-parameter instance.
module tb_branch_target_table;

    logic       Clk = 1'b0;
    logic       Reset_n, flush, rd_en, wr_valid, wr_rel;
    logic [1:0] rd_addr, wr_addr;
    logic [9:0] pc_in, wr_data;
    logic       rd_valid, wr_ready, busy;
    logic [9:0] target;

    logic        rst2_n, flush2, rd_en2, wr_valid2, wr_rel2;
    logic [3:0]  rd_addr2, wr_addr2;
    logic [15:0] pc_in2;
    logic [7:0]  wr_data2;
    logic        rd_valid2, wr_ready2, busy2;
    logic [15:0] target2;

    int vectors = 0;
    int errors  = 0;

    always #5 Clk = ~Clk;

    branch_target_table dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .flush    (flush),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .pc_in    (pc_in),
        .rd_valid (rd_valid),
        .target   (target),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_rel   (wr_rel),
        .busy     (busy)
    );

    branch_target_table #(
        .ADDR_W (4),
        .TGT_W  (8),
        .PC_W   (16)
    ) dut_wide (
        .Clk      (Clk),
        .Reset_n  (rst2_n),
        .flush    (flush2),
        .rd_en    (rd_en2),
        .rd_addr  (rd_addr2),
        .pc_in    (pc_in2),
        .rd_valid (rd_valid2),
        .target   (target2),
        .wr_valid (wr_valid2),
        .wr_ready (wr_ready2),
        .wr_addr  (wr_addr2),
        .wr_data  (wr_data2),
        .wr_rel   (wr_rel2),
        .busy     (busy2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n = 1'b0; flush = 1'b0; rd_en = 1'b0; wr_valid = 1'b0; wr_rel = 1'b0;
        rd_addr = '0; wr_addr = '0; pc_in = '0; wr_data = '0;
        rst2_n = 1'b0; flush2 = 1'b0; rd_en2 = 1'b0; wr_valid2 = 1'b0; wr_rel2 = 1'b0;
        rd_addr2 = '0; wr_addr2 = '0; pc_in2 = '0; wr_data2 = '0;

        #3;
        check("rst_busy", 32'(busy), 1);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_target", 32'(target), 0);
        tick(); tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init_busy_%0d", i), 32'(busy), 1);
            tick();
        end
        check("init_done_busy", 32'(busy), 0);
        check("init_done_wr_ready", 32'(wr_ready), 1);

        // Defaults
        rd_en = 1'b1; rd_addr = 2'd0; pc_in = 10'h010;
        tick();
        check("def0_valid", 32'(rd_valid), 1);
        check("def0_target", 32'(target), 32'h00F);
        rd_addr = 2'd2;
        tick();
        check("def2_target", 32'(target), 32'h000);
        rd_en = 1'b0;

        // Relative wrap
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 10'h005; wr_rel = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_en = 1'b1; rd_addr = 2'd1; pc_in = 10'h3FE;
        tick();
        check("rel_wrap_up", 32'(target), 32'h003);
        rd_en = 1'b0;
        tick();
        check("idle_valid", 32'(rd_valid), 0);
        check("idle_hold", 32'(target), 32'h003);
        // Write addr 1 alongside a read of addr 0
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 10'h3FC; wr_rel = 1'b1;
        rd_en = 1'b1; rd_addr = 2'd0; pc_in = 10'h100;
        tick();
        wr_valid = 1'b0;
        check("indep_read", 32'(target), 32'h0FF);
        rd_addr = 2'd1; pc_in = 10'h002;
        tick();
        check("rel_wrap_down", 32'(target), 32'h3FE);

        // Bypass
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 10'h155; wr_rel = 1'b0;
        rd_addr = 2'd3; pc_in = 10'h200;
        tick();
        wr_valid = 1'b0; rd_en = 1'b0;
        check("bypass_valid", 32'(rd_valid), 1);
        check("bypass_target", 32'(target), 32'h155);

        // Flush in RUN
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 10'h0AA; wr_rel = 1'b0;
        tick();
        wr_valid = 1'b0;
        rd_en = 1'b1; rd_addr = 2'd2;
        tick();
        check("pre_flush_read", 32'(target), 32'h0AA);
        flush = 1'b1; wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 10'h123; wr_rel = 1'b1;
        rd_addr = 2'd3;
        #1;
        check("flush_wr_ready", 32'(wr_ready), 0);
        tick();
        flush = 1'b0; wr_valid = 1'b0;
        check("flush_rd_valid", 32'(rd_valid), 0);
        check("flush_target_hold", 32'(target), 32'h0AA);
        rd_addr = 2'd0; pc_in = 10'h000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_busy_%0d", i), 32'(busy), 1);
            check($sformatf("flush_wr_ready_%0d", i), 32'(wr_ready), 0);
            tick();
            check($sformatf("init_read_drop_%0d", i), 32'(rd_valid), 0);
        end
        check("flush_done_busy", 32'(busy), 0);
        rd_addr = 2'd1; pc_in = 10'h100;
        tick();
        check("flushed_addr1", 32'(target), 32'h000);
        rd_addr = 2'd2;
        tick();
        check("flushed_addr2", 32'(target), 32'h000);
        rd_addr = 2'd0; pc_in = 10'h000;
        tick();
        check("flushed_addr0", 32'(target), 32'h3FF);
        rd_en = 1'b0;

        // Flush during INIT restarts the walk
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reflush_busy_%0d", i), 32'(busy), 1);
            tick();
        end
        check("reflush_done", 32'(busy), 0);

        // Reset mid-INIT
        rd_en = 1'b1; rd_addr = 2'd0; pc_in = 10'h010;
        tick();
        rd_en = 1'b0;
        check("pre_rst_target", 32'(target), 32'h00F);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(); tick();
        Reset_n = 1'b0;
        #1;
        check("mid_init_rst_busy", 32'(busy), 1);
        check("mid_init_rst_valid", 32'(rd_valid), 0);
        check("mid_init_rst_target", 32'(target), 0);
        #3;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_init_busy_%0d", i), 32'(busy), 1);
            tick();
        end
        check("rst_init_done", 32'(busy), 0);

        // Reset mid-read
        rd_en = 1'b1; rd_addr = 2'd0; pc_in = 10'h010;
        tick();
        rd_en = 1'b0;
        check("post_rst_read", 32'(target), 32'h00F);
        Reset_n = 1'b0;
        #1;
        check("mid_read_rst_valid", 32'(rd_valid), 0);
        check("mid_read_rst_target", 32'(target), 0);
        Reset_n = 1'b1;

        // Wide instance
        tick();
        rst2_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wide_busy_%0d", i), 32'(busy2), 1);
            tick();
        end
        check("wide_init_done", 32'(busy2), 0);
        wr_valid2 = 1'b1; wr_addr2 = 4'd5; wr_data2 = 8'h80; wr_rel2 = 1'b1;
        tick();
        wr_valid2 = 1'b0;
        rd_en2 = 1'b1; rd_addr2 = 4'd5; pc_in2 = 16'h0100;
        tick();
        rd_en2 = 1'b0;
        check("wide_valid", 32'(rd_valid2), 1);
        check("wide_rel_target", 32'(target2), 32'h0080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_table.md
BRANCH_TARGET_TABLE -- requirements
Module: branch_target_table

Interface
REQ-001 SHALL provide parameter ADDR_W, default 2: pointer width; table depth is 2^ADDR_W entries.
REQ-002 SHALL provide parameter TGT_W, default 10: stored target/offset width.
REQ-003 SHALL provide parameter PC_W, default 10: PC and output width; PC_W >= TGT_W is required (elaboration error otherwise).
REQ-004 SHALL use a single clock and an asynchronous active-low reset: Clk  in  1  rising-edge clock.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous request to reinitialise the table to defaults.
REQ-007 rd_en  in  1  read request.
REQ-008 rd_addr  in  ADDR_W  read pointer.
REQ-009 pc_in  in  PC_W  current PC, sampled with the read request.
REQ-010 rd_valid  out  1  target output valid.
REQ-011 target  out  PC_W  resolved branch target.
REQ-012 wr_valid  in  1  write request.
REQ-013 wr_ready  out  1  write accepted when high with wr_valid.
REQ-014 wr_addr  in  ADDR_W  write pointer.
REQ-015 wr_data  in  TGT_W  value to store.
REQ-016 wr_rel  in  1  mode of stored entry: 1 = PC-relative signed offset, 0 = absolute.
REQ-017 busy  out  1  table initialising.

Function
REQ-018 SHALL implement FSM states INIT and RUN.
REQ-019 INIT: one entry per cycle written with its default, index counter 0 to 2^ADDR_W-1; after the last entry, next state RUN; INIT lasts exactly 2^ADDR_W cycles.
REQ-020 Defaults: entry 0 = all-ones, relative (offset -1); all other entries = 0, absolute.
REQ-021 busy = 1 in INIT, 0 in RUN.
REQ-022 wr_ready = 1 only in RUN with flush = 0.
REQ-023 A write commits on the rising edge where wr_valid & wr_ready, storing wr_data and wr_rel at wr_addr.
REQ-024 A read is accepted on the rising edge where rd_en = 1 in RUN with flush = 0; rd_addr and pc_in are registered.
REQ-025 Read latency is 1 cycle: rd_valid = 1 in the cycle after acceptance, otherwise 0; target is held from the last accepted read while rd_valid = 0.
REQ-026 Relative entry: target = pc_in + sign-extend(entry to PC_W), modulo 2^PC_W; wraps silently.
REQ-027 Absolute entry: target = zero-extend(entry to PC_W).
REQ-028 Same-edge write and read at the same address: the read returns the new data and mode (write-first).
REQ-029 Same-edge write and read at different addresses: both complete independently.
REQ-030 Read or write requests in INIT are ignored; no queuing.
REQ-031 flush = 1 in RUN: next state INIT with counter 0; writes and reads in that cycle are dropped; rd_valid = 0 next cycle.
REQ-032 flush = 1 in INIT: counter restarts at 0 and INIT lasts a full 2^ADDR_W cycles from that edge.

Reset
REQ-033 Reset_n = 0 asynchronously forces: state INIT, counter 0, busy = 1, wr_ready = 0, rd_valid = 0, target = 0.
REQ-034 Table contents are undefined during reset and become valid through INIT only; no read is accepted before that.
REQ-035 Reset asserted mid-INIT or mid-read aborts the operation immediately; the deassert edge starts a fresh INIT.

Verification
REQ-036 Reset release, defaults (ADDR_W=2, PC_W=10): busy = 1 for exactly 4 cycles, then read addr 0 with pc_in = 0x010 -> target = 0x00F next cycle; read addr 2 -> 0x000.
REQ-037 Relative wrap: write addr 1 = 0x005 rel; read with pc_in = 0x3FE -> target = 0x003; write 0x3FC rel, pc_in = 0x002 -> target = 0x3FE.
REQ-038 Bypass: write addr 3 = 0x155 abs on the same edge as a read of addr 3 -> target = 0x155, rd_valid = 1 next cycle.
REQ-039 Flush: write addr 2 = 0x0AA, assert flush one cycle with a coincident write to addr 1 -> busy = 1 for 4 cycles, wr_ready = 0; afterwards addr 1 and addr 2 read 0x000.
REQ-040 Reset mid-INIT: drop Reset_n at INIT cycle 2 -> busy, rd_valid, and target show reset values immediately; after release, INIT takes 4 full cycles.
REQ-041 Parameter sweep ADDR_W=4, TGT_W=8, PC_W=16: INIT takes 16 cycles; a relative entry 0x80 with pc_in = 0x0100 -> target = 0x0080.
